wavelet_sample_driver: RTL and testbench
========================================

// Module: wavelet_sample_driver
// PURPOSE
//  Transmit side of the sample-input interface: buffers incoming signed samples in a small FIFO
//  and replays them as a paced (value, data-strobe) stream that feeds the wavelet transform core's
//  i_value / i_data_clk pins. Guarantees value setup before each strobe rising edge and a
//  programmable minimum sample period, so every FIR bank finishes its sum before the next shift.
// PARAMETERS
//  BITS_PER_ELEM   8   sample width (signed, two's complement)
//  FIFO_DEPTH      4   sample buffer entries; power of two, >=2
//  STROBE_CYCLES   2   clk cycles o_data_clk is held high per sample, >=1
//  PERIOD_BITS     16  width of i_period
// PORTS
//  clk             in   1              system clock, all logic on rising edge
//  rst_n           in   1              synchronous reset, active low
//  i_sample        in   BITS_PER_ELEM  signed sample to enqueue
//  i_sample_valid  in   1              i_sample valid this cycle
//  o_sample_ready  out  1              FIFO can accept; push = valid & ready
//  i_period        in   PERIOD_BITS    clk cycles from one strobe rise to the next
//  i_clear         in   1              clears sticky o_underrun
//  o_value         out  BITS_PER_ELEM  sample presented to core i_value
//  o_data_clk      out  1              sample strobe to core i_data_clk (core acts on rising edge)
//  o_busy          out  1              FSM not in IDLE
//  o_fifo_level    out  $clog2(FIFO_DEPTH)+1  entries held
//  o_underrun      out  1              sticky: period expired with FIFO empty
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): o_value=0, o_data_clk=0, o_busy=0, o_fifo_level=0, o_underrun=0,
//   o_sample_ready=0; FIFO flushed; FSM->IDLE. Mid-strobe reset drops o_data_clk next edge.
//  o_sample_ready = rst_n_registered & (level != FIFO_DEPTH); registered, 1 the cycle after reset.
//  FIFO: push/pop same cycle at any level leaves level unchanged; pops only occur in SETUP.
//  FSM (all outputs registered):
//   IDLE : o_data_clk=0. level!=0 -> SETUP. Pushes landing this cycle are seen next cycle.
//   SETUP: 1 cycle. o_value<=FIFO head, pop; latch eff_period=max(i_period, STROBE_CYCLES+2);
//          period counter<=1. o_data_clk stays 0 (>=1 cycle value setup). -> HIGH.
//   HIGH : o_data_clk=1 for exactly STROBE_CYCLES cycles; counter++. -> LOW.
//   LOW  : o_data_clk=0; counter++ until counter==eff_period-1, then: level!=0 -> SETUP;
//          level==0 -> underrun handling (below).
//  Strobe rises are exactly eff_period clks apart while FIFO never empties. o_value changes only
//   in SETUP, so it is stable across the whole HIGH phase and the preceding cycle.
//  i_period changes take effect at the next SETUP only; i_period < STROBE_CYCLES+2 is clamped.
//  Underrun: LOW expiry with level==0 sets o_underrun=1 (held until i_clear or reset).
//   i_clear and a new underrun in the same cycle -> o_underrun=1 (set wins).
//  o_busy=1 in SETUP/HIGH/LOW.
// CONFIGURATION
//  DRIVER_ZERO_FILL_EN defined: on underrun FSM goes to SETUP with o_value<=0 (no pop), keeping
//   the strobe cadence so core filters decay; real samples resume at the first SETUP with level!=0.
//   o_busy stays 1 until reset.
//  Not defined: on underrun FSM -> IDLE, o_value holds last sample, no strobe until next push.
//  o_underrun sets identically in both builds.
// TESTING
//  1) Reset then push 8'h7F,8'h81,8'h00 back to back, i_period=10 -> o_data_clk rises at 10-clk
//     spacing, o_value=7F/81/00 each held >=1 clk before rise; high width 2 clks.
//  2) Push 5 samples with FIFO_DEPTH=4, no drain in IDLE race -> o_sample_ready=0 at level 4,
//     5th accepted only after first SETUP pop; no sample lost or duplicated.
//  3) i_period=1 -> clamped; strobe rises every 4 clks (STROBE_CYCLES=2).
//  4) Single push then nothing -> one strobe, o_underrun=1 at period end; i_clear -> 0.
//     With DRIVER_ZERO_FILL_EN: strobes continue with o_value=0 every period.
//  5) rst_n low during HIGH -> next edge o_data_clk=0, level=0, o_busy=0, o_underrun=0.
//  6) Change i_period 10->20 mid-stream -> current period stays 10, next period 20.

Source files
------------

// File: rtl/wavelet_sample_driver.sv
// wavelet_sample_driver
//   Buffers signed samples in a small FIFO and replays them as a paced
//   (o_value, o_data_clk) stream for the wavelet core's i_value/i_data_clk.
//   Every sample period runs one SETUP cycle, STROBE_CYCLES HIGH cycles, and
//   then LOW cycles. Consecutive strobe rises are eff_period clocks apart.
//   o_value changes only on entry to SETUP, so it is settled at least one
//   clock before each strobe rise.
//   Build option: define DRIVER_ZERO_FILL_EN to keep strobing with zero
//   samples after an underrun. Left undefined, the driver idles until the
//   next push.
module wavelet_sample_driver #(
  parameter int BITS_PER_ELEM = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int STROBE_CYCLES = 2,
  parameter int PERIOD_BITS   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic signed [BITS_PER_ELEM-1:0] i_sample,
  input  logic                            i_sample_valid,
  output logic                            o_sample_ready,
  input  logic [PERIOD_BITS-1:0]          i_period,
  input  logic                            i_clear,
  output logic signed [BITS_PER_ELEM-1:0] o_value,
  output logic                            o_data_clk,
  output logic                            o_busy,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level,
  output logic                            o_underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [PERIOD_BITS-1:0] P_ONE      = PERIOD_BITS'(1);
  localparam logic [PERIOD_BITS-1:0] P_STROBE   = PERIOD_BITS'(STROBE_CYCLES);
  localparam logic [PERIOD_BITS-1:0] MIN_PERIOD = PERIOD_BITS'(STROBE_CYCLES + 2);
  localparam logic [LW-1:0]          L_FULL     = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic signed [BITS_PER_ELEM-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]          level_q, level_d;
  logic                   ready_q;
  logic                   push, pop, fill;

  logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
  logic [PERIOD_BITS-1:0] eff_q, eff_d;
  logic signed [BITS_PER_ELEM-1:0] value_q, value_d;
  logic                   dclk_q, busy_q, under_q;
  logic                   under_set;

  assign push = i_sample_valid & ready_q;

  // Next-state logic. Work attributed to SETUP (pop, value load, period
  // latch) is performed on the edge that enters SETUP. The new value is
  // therefore on o_value for the whole SETUP cycle, before the strobe rises.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    eff_d     = eff_q;
    value_d   = value_q;
    pop       = 1'b0;
    fill      = 1'b0;
    under_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (level_q != '0) begin
          state_d = ST_SETUP;
          pop     = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d = ST_HIGH;
        cnt_d   = P_ONE;
      end
      ST_HIGH: begin
        cnt_d = cnt_q + P_ONE;
        if (cnt_q == P_STROBE) state_d = ST_LOW;
      end
      ST_LOW: begin
        cnt_d = cnt_q + P_ONE;
        if (cnt_q == eff_q - P_ONE) begin
          if (level_q != '0) begin
            state_d = ST_SETUP;
            pop     = 1'b1;
          end else begin
            under_set = 1'b1;
`ifdef DRIVER_ZERO_FILL_EN
            state_d = ST_SETUP;
            fill    = 1'b1;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop || fill) begin
      eff_d   = (i_period < MIN_PERIOD) ? MIN_PERIOD : i_period;
      value_d = pop ? mem[rd_ptr_q] : '0;
    end
  end

  assign level_d = level_q + LW'(push) - LW'(pop);

  // Sample storage. It has no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= i_sample;
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      ready_q <= (level_d != L_FULL);
    end
  end

  // FSM state, period counter and latched effective period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      eff_q   <= MIN_PERIOD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eff_q   <= eff_d;
    end
  end

  // Registered outputs. They are derived from the next state, so each output
  // is in step with the state it describes. A set and a clear of the
  // underrun flag in the same cycle leaves the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
      dclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      value_q <= value_d;
      dclk_q  <= (state_d == ST_HIGH);
      busy_q  <= (state_d != ST_IDLE);
      under_q <= under_set | (under_q & ~i_clear);
    end
  end

  assign o_sample_ready = ready_q;
  assign o_value        = value_q;
  assign o_data_clk     = dclk_q;
  assign o_busy         = busy_q;
  assign o_fifo_level   = level_q;
  assign o_underrun     = under_q;

endmodule

// File: tb/tb_wavelet_sample_driver.sv
// Testbench for wavelet_sample_driver: a directed sequence followed by a
// random phase. Every cycle, all outputs are compared against a schedule-level
// reference model. That model holds a sample queue and the cycle number at
// which each period started.
module tb_wavelet_sample_driver;

  localparam int BPE   = 8;
  localparam int DEPTH = 4;
  localparam int S     = 2;
  localparam int PB    = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [BPE-1:0] i_sample = '0;
  logic           i_sample_valid = 1'b0;
  logic           o_sample_ready;
  logic [PB-1:0]  i_period = PB'(10);
  logic           i_clear = 1'b0;
  logic [BPE-1:0] o_value;
  logic           o_data_clk;
  logic           o_busy;
  logic [2:0]     o_fifo_level;
  logic           o_underrun;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wavelet_sample_driver #(
    .BITS_PER_ELEM(BPE),
    .FIFO_DEPTH(DEPTH),
    .STROBE_CYCLES(S),
    .PERIOD_BITS(PB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_sample(i_sample),
    .i_sample_valid(i_sample_valid),
    .o_sample_ready(o_sample_ready),
    .i_period(i_period),
    .i_clear(i_clear),
    .o_value(o_value),
    .o_data_clk(o_data_clk),
    .o_busy(o_busy),
    .o_fifo_level(o_fifo_level),
    .o_underrun(o_underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model. A period starts at its SETUP cycle (m_setup) and lasts
  // m_eff cycles. The strobe is high for offsets 1..S of the period.
  logic [BPE-1:0] mq[$];
  bit             m_active = 1'b0;
  bit             m_under = 1'b0;
  bit             m_ready = 1'b0;
  int             m_setup = 0;
  int             m_eff = 0;
  int             n = 0;
  logic [BPE-1:0] m_value = '0;
  int             pre_level;
  bit             enter, do_pop, uset;
  bit             model_valid = 1'b0;
  bit             exp_dclk, exp_busy;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_active = 1'b0;
      m_under  = 1'b0;
      m_ready  = 1'b0;
      m_value  = '0;
    end else begin
      pre_level = mq.size();
      enter  = 1'b0;
      do_pop = 1'b0;
      uset   = 1'b0;
      if (!m_active) begin
        if (pre_level != 0) begin enter = 1'b1; do_pop = 1'b1; end
      end else if (n - m_setup == m_eff - 1) begin
        if (pre_level != 0) begin
          enter = 1'b1; do_pop = 1'b1;
        end else begin
          uset = 1'b1;
`ifdef DRIVER_ZERO_FILL_EN
          enter = 1'b1;
`else
          m_active = 1'b0;
`endif
        end
      end
      m_under = uset ? 1'b1 : (i_clear ? 1'b0 : m_under);
      if (do_pop) m_value = mq.pop_front();
      else if (enter) m_value = '0;
      if (i_sample_valid && m_ready) mq.push_back(i_sample);
      if (enter) begin
        m_active = 1'b1;
        m_setup  = n + 1;
        m_eff    = (int'(i_period) < S + 2) ? S + 2 : int'(i_period);
      end
      m_ready = (mq.size() != DEPTH);
    end
    n++;
    exp_dclk = m_active && (n - m_setup >= 1) && (n - m_setup <= S);
    exp_busy = m_active;
    model_valid = 1'b1;
  end

  // Per-cycle comparison and strobe-rise logging. It runs away from the active edge.
  int             negcnt = 0;
  logic           prev_dclk = 1'b0;
  int             rise_t[$];
  logic [BPE-1:0] rise_v[$];

  always @(negedge clk) begin
    if (model_valid) begin
      chk("dclk", 32'(o_data_clk), 32'(exp_dclk));
      chk("value", 32'(o_value), 32'(m_value));
      chk("busy", 32'(o_busy), 32'(exp_busy));
      chk("level", 32'(o_fifo_level), 32'(mq.size()));
      chk("underrun", 32'(o_underrun), 32'(m_under));
      chk("ready", 32'(o_sample_ready), 32'(m_ready));
      if (o_data_clk === 1'b1 && prev_dclk === 1'b0) begin
        rise_t.push_back(negcnt);
        rise_v.push_back(o_value);
      end
      prev_dclk = o_data_clk;
    end
    negcnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    step();
    rst_n = 1'b0;
    i_sample_valid = 1'b0;
    i_clear = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    rise_t.delete();
    rise_v.delete();
  endtask

  task automatic push(input logic [BPE-1:0] v);
    int b;
    i_sample = v;
    i_sample_valid = 1'b1;
    b = 0;
    while (!m_ready && b < 300) begin step(); b++; end
    if (b >= 300) begin
      checks++; failures++;
      $error("FAIL push_timeout: observed=not_ready expected=ready");
    end
    step();
    i_sample_valid = 1'b0;
  endtask

  task automatic wait_rises(input int cnt, input int budget);
    int b;
    b = 0;
    while (rise_t.size() < cnt && b < budget) begin step(); b++; end
    if (rise_t.size() < cnt) begin
      checks++; failures++;
      $error("FAIL rise_timeout: observed=%0d expected=%0d", rise_t.size(), cnt);
    end
  endtask

  logic [BPE-1:0] pushed[$];

  initial begin
    // Reset state and first-cycle readiness
    reset_dut();
    chk("rst_ready", 32'(o_sample_ready), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_level", 32'(o_fifo_level), 32'd0);
    chk("rst_dclk", 32'(o_data_clk), 32'd0);
    step();
    chk("ready_after_rst", 32'(o_sample_ready), 32'd1);

    // Test 1: three samples, period 10
    i_period = PB'(10);
    push(8'h7F); push(8'h81); push(8'h00);
    wait_rises(3, 60);
    chk("t1_v0", 32'(rise_v[0]), 32'h7F);
    chk("t1_v1", 32'(rise_v[1]), 32'h81);
    chk("t1_v2", 32'(rise_v[2]), 32'h00);
    chk("t1_gap0", 32'(rise_t[1] - rise_t[0]), 32'd10);
    chk("t1_gap1", 32'(rise_t[2] - rise_t[1]), 32'd10);

    // Test 2: fill the FIFO behind a long period; check that nothing is lost or duplicated
    reset_dut();
    i_period = PB'(20);
    pushed.delete();
    for (int unsigned k = 0; k < 5; k++) begin
      pushed.push_back(BPE'($urandom));
      push(pushed[k]);
    end
    chk("t2_full_level", 32'(o_fifo_level), 32'd4);
    chk("t2_full_ready", 32'(o_sample_ready), 32'd0);
    pushed.push_back(BPE'($urandom));
    push(pushed[5]);
    wait_rises(6, 200);
    for (int unsigned k = 0; k < 6; k++) chk("t2_order", 32'(rise_v[k]), 32'(pushed[k]));

    // Test 3: a period below the minimum is clamped to S+2
    reset_dut();
    i_period = PB'(1);
    push(8'h11); push(8'h22); push(8'h33);
    wait_rises(3, 40);
    chk("t3_gap0", 32'(rise_t[1] - rise_t[0]), 32'(S + 2));
    chk("t3_gap1", 32'(rise_t[2] - rise_t[1]), 32'(S + 2));

    // Test 4: single sample, then underrun and clear
    reset_dut();
    i_period = PB'(6);
    push(8'h5A);
    wait_rises(1, 20);
    for (int unsigned k = 0; k < 6; k++) step();
    chk("t4_underrun", 32'(o_underrun), 32'd1);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("t4_cleared", 32'(o_underrun), 32'd0);
`ifdef DRIVER_ZERO_FILL_EN
    wait_rises(3, 40);
    chk("t4_zf_v1", 32'(rise_v[1]), 32'd0);
    chk("t4_zf_v2", 32'(rise_v[2]), 32'd0);
    chk("t4_zf_gap", 32'(rise_t[2] - rise_t[1]), 32'd6);
`else
    for (int unsigned k = 0; k < 20; k++) step();
    chk("t4_one_strobe", 32'(rise_t.size()), 32'd1);
    chk("t4_idle", 32'(o_busy), 32'd0);
    chk("t4_hold", 32'(o_value), 32'h5A);
`endif

    // Test 5: reset asserted during HIGH
    reset_dut();
    i_period = PB'(1);
    push(8'h01);
    for (int unsigned k = 0; k < 8; k++) step();
    chk("t5_pre_under", 32'(o_underrun), 32'd1);
    push(8'h02); push(8'h03); push(8'h04);
    begin
      int b;
      b = 0;
      while (o_data_clk !== 1'b1 && b < 40) begin step(); b++; end
      if (o_data_clk !== 1'b1) begin
        checks++; failures++;
        $error("FAIL t5_wait_high: observed=%0b expected=1", o_data_clk);
      end
    end
    rst_n = 1'b0;
    step();
    chk("t5_dclk", 32'(o_data_clk), 32'd0);
    chk("t5_level", 32'(o_fifo_level), 32'd0);
    chk("t5_busy", 32'(o_busy), 32'd0);
    chk("t5_under", 32'(o_underrun), 32'd0);
    rst_n = 1'b1;

    // Test 6: a change of period takes effect at the next SETUP only
    reset_dut();
    i_period = PB'(10);
    push(8'hA1); push(8'hA2); push(8'hA3);
    wait_rises(1, 20);
    i_period = PB'(20);
    wait_rises(3, 80);
    chk("t6_gap0", 32'(rise_t[1] - rise_t[0]), 32'd10);
    chk("t6_gap1", 32'(rise_t[2] - rise_t[1]), 32'd20);

    // Random phase: random pushes, periods and clears, checked every cycle by the model
    reset_dut();
    for (int unsigned k = 0; k < 900; k++) begin
      i_sample       = BPE'($urandom);
      i_sample_valid = ($urandom_range(0, 2) == 0);
      i_clear        = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0) i_period = PB'($urandom_range(1, 12));
      step();
    end
    i_sample_valid = 1'b0;
    i_clear = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
